// File: rtl/postbox_pkg.sv
// Shared types and helpers for the POST-box INPUT responder.
package postbox_pkg;

    // Responder protocol states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Host command pulse counts (only INPUT is decoded today)
    localparam int unsigned INPUT_PULSES_DEF  = 4;
    localparam int unsigned OUTPUT_PULSES_DEF = 5;
    localparam int unsigned STATUS_PULSES_DEF = 6;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/postbox_tx_fifo.sv
// Synchronous TX FIFO with occupancy output; accepts a push while full when a pop
// happens in the same cycle.
module postbox_tx_fifo
    import postbox_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_pop,
    output logic [DATA_W-1:0]     o_rdata_c,
    output logic                  o_full_c,
    output logic                  o_empty_c,
    output logic [clog2(DEPTH):0] o_level
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full_c  = (r_count == LVL_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_level   = r_count;
    assign w_rd      = i_pop && !o_empty_c;
    assign w_wr      = i_push && (!o_full_c || w_rd);

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers (natural power-of-two wrap) and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/postbox_input_chain.sv
// POST-box INPUT responder: decodes the host INPUT command from testreq pulses,
// inserts NACK waits until TX data exists, then serialises chained words on testack.
module postbox_input_chain
    import postbox_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned INPUT_PULSES = INPUT_PULSES_DEF,
    parameter int unsigned BREAK_CYCLES = 50,
    parameter int unsigned MAX_WAIT     = 255,
    parameter int unsigned MSB_FIRST    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                       refclk,
    input  logic                       reset,
    input  logic                       testreq,
    output logic                       testack,
    input  logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [clog2(FIFO_DEPTH):0] fifo_level,
    output logic                       busy,
    output logic                       timeout,
    output logic                       aborted
);

    localparam int unsigned PCNT_W = clog2(INPUT_PULSES + 1);
    localparam int unsigned WCNT_W = clog2(MAX_WAIT + 1);
    localparam int unsigned BCNT_W = clog2(BREAK_CYCLES + 1);
    localparam int unsigned BIT_W  = clog2(DATA_W + 1);

    state_e                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_d;
    logic [BCNT_W-1:0]      r_low_cnt;
    logic [PCNT_W-1:0]      r_pulse_cnt;
    logic [WCNT_W-1:0]      r_wait_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_testack;
    logic                   r_timeout;
    logic                   r_aborted;

    logic                   w_req;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_break;
    logic                   w_wait_step;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_next_bit;
    logic [DATA_W-1:0]      w_shift_next;
    logic [DATA_W-1:0]      w_fifo_rdata;
    logic [WCNT_W-1:0]      w_wait_base;
    logic [WCNT_W-1:0]      w_wait_inc;

    postbox_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (refclk),
        .reset     (reset),
        .i_push    (tx_valid),
        .i_wdata   (tx_data),
        .i_pop     (w_pop),
        .o_rdata_c (w_fifo_rdata),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty),
        .o_level   (fifo_level)
    );

    assign w_req    = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_req && !r_req_d;
    assign w_fall   = !w_req && r_req_d;
    assign w_break  = !w_req && (r_low_cnt == BCNT_W'(BREAK_CYCLES - 1));

    assign testack  = r_testack;
    assign timeout  = r_timeout;
    assign aborted  = r_aborted;
    assign busy     = (r_state != ST_IDLE);
    assign tx_ready = !w_fifo_full;

    // Falling edge that runs the ACK/NACK decision: end of command, waiting, or word finished
    assign w_wait_step = w_fall && !w_break &&
                         (((r_state == ST_IDLE) && (r_pulse_cnt == PCNT_W'(INPUT_PULSES))) ||
                          (r_state == ST_WAIT) ||
                          ((r_state == ST_DATA) && (r_bit_cnt == BIT_W'(DATA_W))));
    assign w_pop = w_wait_step && !w_fifo_empty;

    // Synchroniser, edge history and break-length low counter (saturating so a break fires once)
    always_ff @(posedge refclk) begin
        if (reset) begin
            r_sync    <= '0;
            r_req_d   <= 1'b0;
            r_low_cnt <= '0;
        end else begin
            r_sync  <= (r_sync << 1) | SYNC_STAGES'(testreq);
            r_req_d <= w_req;
            if (w_req) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != BCNT_W'(BREAK_CYCLES)) begin
                r_low_cnt <= r_low_cnt + BCNT_W'(1);
            end
        end
    end

    // Next serial bit and shifted remainder for the configured bit order
    always_comb begin
        w_next_bit   = 1'b0;
        w_shift_next = r_shift;
        if (MSB_FIRST != 0) begin
            w_next_bit   = r_shift[DATA_W-1];
            w_shift_next = r_shift << 1;
        end else begin
            w_next_bit   = r_shift[0];
            w_shift_next = r_shift >> 1;
        end
    end

    // Wait count restarts from zero when the step comes straight from a command; saturates
    always_comb begin
        w_wait_base = (r_state == ST_IDLE) ? '0 : r_wait_cnt;
        w_wait_inc  = w_wait_base;
        if (w_wait_base != WCNT_W'(MAX_WAIT)) begin
            w_wait_inc = w_wait_base + WCNT_W'(1);
        end
    end

    // Protocol state machine; testack only moves on a synced falling edge or a break
    always_ff @(posedge refclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pulse_cnt <= '0;
            r_wait_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_testack   <= 1'b0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            if (w_break) begin
                r_state     <= ST_IDLE;
                r_pulse_cnt <= '0;
                r_testack   <= 1'b0;
                r_aborted   <= (r_state == ST_DATA);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise && (r_pulse_cnt != PCNT_W'(INPUT_PULSES))) begin
                            r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
                        end
                        if (w_wait_step) begin
                            r_pulse_cnt <= '0;
                            r_timeout   <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (w_fall && (r_bit_cnt != BIT_W'(DATA_W))) begin
                            r_testack <= w_next_bit;
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase

                // ACK and load the next word, or NACK and count a wait state
                if (w_wait_step) begin
                    if (!w_fifo_empty) begin
                        r_shift    <= w_fifo_rdata;
                        r_testack  <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_wait_cnt <= w_wait_base;
                        r_state    <= ST_DATA;
                    end else begin
                        r_testack  <= 1'b0;
                        r_wait_cnt <= w_wait_inc;
                        if (w_wait_inc == WCNT_W'(MAX_WAIT)) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_HALT;
                        end else begin
                            r_state   <= ST_WAIT;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_postbox_input_chain.sv
// Directed bench for postbox_input_chain: three instances (default, 12-bit LSB-first,
// short wait limit) share clock, reset and testreq; each has its own TX port.
module tb_postbox_input_chain;

    localparam int HI = 6;
    localparam int LO = 6;

    logic        refclk;
    logic        reset;
    logic        testreq;

    logic [7:0]  tx_data0, tx_data2;
    logic [11:0] tx_data1;
    logic        tx_valid0, tx_valid1, tx_valid2;
    logic        testack0, testack1, testack2;
    logic        tx_ready0, tx_ready1, tx_ready2;
    logic [2:0]  fifo_level0, fifo_level1, fifo_level2;
    logic        busy0, busy1, busy2;
    logic        timeout0, timeout1, timeout2;
    logic        aborted0, aborted1, aborted2;

    logic        s_ack0, s_ack1, s_ack2;
    int          n_total;
    int          n_bad;
    int          n_abort0;

    postbox_input_chain dut0 (
        .refclk(refclk), .reset(reset), .testreq(testreq), .testack(testack0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .fifo_level(fifo_level0), .busy(busy0), .timeout(timeout0), .aborted(aborted0)
    );

    postbox_input_chain #(.DATA_W(12), .MSB_FIRST(0)) dut1 (
        .refclk(refclk), .reset(reset), .testreq(testreq), .testack(testack1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .fifo_level(fifo_level1), .busy(busy1), .timeout(timeout1), .aborted(aborted1)
    );

    postbox_input_chain #(.MAX_WAIT(5)) dut2 (
        .refclk(refclk), .reset(reset), .testreq(testreq), .testack(testack2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .fifo_level(fifo_level2), .busy(busy2), .timeout(timeout2), .aborted(aborted2)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    always @(posedge refclk) begin
        if (aborted0) n_abort0 <= n_abort0 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        testreq   = 1'b0;
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
        tx_valid2 = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input int inst, input logic [11:0] d);
        case (inst)
            0:       begin tx_data0 = d[7:0]; tx_valid0 = 1'b1; end
            1:       begin tx_data1 = d;      tx_valid1 = 1'b1; end
            default: begin tx_data2 = d[7:0]; tx_valid2 = 1'b1; end
        endcase
        @(posedge refclk);
        #1;
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    // mode 0: plain pulse; 1: push tx_data0 at start of high; 2: push tx_data0 in the fall-decode cycle
    task automatic pulse(input int mode);
        testreq = 1'b1;
        if (mode == 1) begin
            tx_valid0 = 1'b1;
            @(posedge refclk);
            #1;
            tx_valid0 = 1'b0;
            repeat (HI - 1) @(posedge refclk);
        end else begin
            repeat (HI) @(posedge refclk);
        end
        #1;
        s_ack0  = testack0;
        s_ack1  = testack1;
        s_ack2  = testack2;
        testreq = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        if (mode == 2) tx_valid0 = 1'b1;
        @(posedge refclk);
        #1;
        tx_valid0 = 1'b0;
        repeat (LO - 3) @(posedge refclk);
        #1;
    endtask

    task automatic do_break();
        testreq = 1'b0;
        repeat (60) @(posedge refclk);
        #1;
    endtask

    initial begin
        logic [7:0]  w8;
        logic [11:0] w12;
        logic [21:0] exp2;
        int          a0;

        n_total  = 0;
        n_bad    = 0;
        n_abort0 = 0;
        tx_data0 = '0;
        tx_data1 = '0;
        tx_data2 = '0;
        reset    = 1'b1;
        testreq  = 1'b0;

        // Reset state of all instances
        do_reset();
        check_val("rst_ack", {29'd0, testack0, testack1, testack2}, 32'd0);
        check_val("rst_level", {23'd0, fifo_level0, fifo_level1, fifo_level2}, 32'd0);
        check_val("rst_ready", {29'd0, tx_ready0, tx_ready1, tx_ready2}, 32'h7);
        check_val("rst_busy", {29'd0, busy0, busy1, busy2}, 32'd0);
        check_val("rst_timeout", {29'd0, timeout0, timeout1, timeout2}, 32'd0);
        check_val("rst_aborted", {29'd0, aborted0, aborted1, aborted2}, 32'd0);

        // NACK waits, push during the third, then 0x5A serialised MSB first
        for (int i = 1; i <= 4; i++) begin
            pulse(0);
            check_val($sformatf("t1_cmd_p%0d", i), 32'(s_ack0), 32'd0);
        end
        check_val("t1_busy_wait", 32'(busy0), 32'd1);
        pulse(0);
        check_val("t1_p5", 32'(s_ack0), 32'd0);
        pulse(0);
        check_val("t1_p6", 32'(s_ack0), 32'd0);
        tx_data0 = 8'h5A;
        pulse(1);
        check_val("t1_p7", 32'(s_ack0), 32'd0);
        check_val("t1_shift", 32'(dut0.r_shift), 32'h5A);
        pulse(0);
        check_val("t1_p8_ack", 32'(s_ack0), 32'd1);
        w8 = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            pulse(0);
            check_val($sformatf("t1_bit%0d", i), 32'(s_ack0), 32'(w8[i]));
        end
        pulse(0);
        check_val("t1_nack_after", 32'(s_ack0), 32'd0);
        check_val("t1_busy", 32'(busy0), 32'd1);
        do_break();
        check_val("t1_busy_brk", 32'(busy0), 32'd0);
        check_val("t1_ack_brk", 32'(testack0), 32'd0);

        // Two words chained without NACK between them
        do_reset();
        push(0, 12'h0A5);
        push(0, 12'h03C);
        check_val("t2_level", 32'(fifo_level0), 32'd2);
        exp2 = {4'b0000, 1'b1, 8'hA5, 1'b1, 8'h3C};
        for (int i = 1; i <= 22; i++) begin
            pulse(0);
            check_val($sformatf("t2_p%0d", i), 32'(s_ack0), 32'(exp2[22 - i]));
        end
        check_val("t2_level_end", 32'(fifo_level0), 32'd0);
        a0 = n_abort0;
        do_reset();
        check_val("t2_reset_no_abort", 32'(n_abort0), 32'(a0));
        check_val("t2_busy_rst", 32'(busy0), 32'd0);

        // 12-bit LSB-first instance
        push(1, 12'h123);
        for (int i = 1; i <= 4; i++) pulse(0);
        pulse(0);
        check_val("t3_ack", 32'(s_ack1), 32'd1);
        w12 = 12'h123;
        for (int i = 0; i < 12; i++) begin
            pulse(0);
            check_val($sformatf("t3_bit%0d", i), 32'(s_ack1), 32'(w12[i]));
        end

        // Wait-state timeout, HALT ignores pulses, timeout clears on next command
        do_reset();
        for (int i = 1; i <= 4; i++) pulse(0);
        for (int i = 5; i <= 8; i++) begin
            check_val($sformatf("t4_to_before_p%0d", i), 32'(timeout2), 32'd0);
            pulse(0);
            check_val($sformatf("t4_p%0d", i), 32'(s_ack2), 32'd0);
        end
        check_val("t4_timeout_set", 32'(timeout2), 32'd1);
        push(2, 12'h0FF);
        for (int i = 9; i <= 14; i++) begin
            pulse(0);
            check_val($sformatf("t4_halt_p%0d", i), 32'(s_ack2), 32'd0);
        end
        check_val("t4_busy_halt", 32'(busy2), 32'd1);
        check_val("t4_level_halt", 32'(fifo_level2), 32'd1);
        do_break();
        check_val("t4_busy_brk", 32'(busy2), 32'd0);
        check_val("t4_timeout_sticky", 32'(timeout2), 32'd1);
        for (int i = 1; i <= 4; i++) pulse(0);
        check_val("t4_timeout_clr", 32'(timeout2), 32'd0);
        pulse(0);
        check_val("t4_ack_new", 32'(s_ack2), 32'd1);

        // Break in the middle of a word
        do_reset();
        push(0, 12'h0C3);
        push(0, 12'h081);
        for (int i = 1; i <= 4; i++) pulse(0);
        pulse(0);
        check_val("t5_ack", 32'(s_ack0), 32'd1);
        w8 = 8'hC3;
        for (int i = 7; i >= 5; i--) begin
            pulse(0);
            check_val($sformatf("t5_bit%0d", i), 32'(s_ack0), 32'(w8[i]));
        end
        a0 = n_abort0;
        do_break();
        check_val("t5_abort_once", 32'(n_abort0 - a0), 32'd1);
        check_val("t5_busy", 32'(busy0), 32'd0);
        check_val("t5_ack_low", 32'(testack0), 32'd0);
        check_val("t5_level", 32'(fifo_level0), 32'd1);
        for (int i = 1; i <= 4; i++) pulse(0);
        pulse(0);
        check_val("t5_ack2", 32'(s_ack0), 32'd1);
        w8 = 8'h81;
        for (int i = 7; i >= 0; i--) begin
            pulse(0);
            check_val($sformatf("t5_w2_bit%0d", i), 32'(s_ack0), 32'(w8[i]));
        end
        do_break();

        // Full FIFO, rejected push, push+pop in the same cycle while full
        do_reset();
        push(0, 12'h011);
        push(0, 12'h022);
        push(0, 12'h033);
        check_val("t6_ready3", 32'(tx_ready0), 32'd1);
        check_val("t6_level3", 32'(fifo_level0), 32'd3);
        push(0, 12'h044);
        check_val("t6_ready4", 32'(tx_ready0), 32'd0);
        check_val("t6_level4", 32'(fifo_level0), 32'd4);
        push(0, 12'h055);
        check_val("t6_level_rej", 32'(fifo_level0), 32'd4);
        for (int i = 1; i <= 3; i++) pulse(0);
        tx_data0 = 8'h66;
        pulse(2);
        check_val("t6_level_pushpop", 32'(fifo_level0), 32'd4);
        pulse(0);
        check_val("t6_ack", 32'(s_ack0), 32'd1);
        w8 = 8'h11;
        for (int i = 7; i >= 0; i--) begin
            pulse(0);
            check_val($sformatf("t6_bit%0d", i), 32'(s_ack0), 32'(w8[i]));
        end
        do_break();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/postbox_input_chain.md
Name: postbox_input_chain

Overview:
- Parametrised successor to the single-byte POST-box INPUT responder.
- Decodes the host's INPUT command from a testreq pulse count and inserts NACK wait states until data is available.
- Serialises DATA_W-bit words on testack and chains further words without a new command, fed from an internal TX FIFO.
- Adds wait-state timeout, break abort, selectable bit order and status outputs. Sits between the adapter's transmit logic and the POST port.

Parameters:
DATA_W, 8, bits per transferred word
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)
INPUT_PULSES, 4, pulse count that selects INPUT
BREAK_CYCLES, 50, refclk cycles of testreq low that constitute a break (25us at 2MHz)
MAX_WAIT, 255, NACK wait states before timeout
MSB_FIRST, 1, 1 = MSB sent first, 0 = LSB first
SYNC_STAGES, 2, testreq synchroniser depth

Ports:
refclk  in  1  system clock, 2MHz nominal
reset  in  1  synchronous, active-high reset
testreq  in  1  host pulse line, asynchronous
testack  out  1  response line to host
tx_data  in  DATA_W  word to push
tx_valid  in  1  push request
tx_ready  out  1  FIFO not full; push accepted when tx_valid&tx_ready at posedge refclk
fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
busy  out  1  state != IDLE
timeout  out  1  sticky; set on wait-state timeout, cleared by reset or next accepted INPUT command
aborted  out  1  one-cycle pulse when a break interrupts DATA

Behaviour:
- Reset values: testack=0, FIFO empty, fifo_level=0, tx_ready=1, state IDLE, pulse and wait counters 0, timeout=0, aborted=0.
- Synchronisation:
  - testreq passes through SYNC_STAGES flops, then an edge detector.
  - Host pulse high and low times must each be >= SYNC_STAGES+2 refclk cycles.
- Response timing:
  - "Response for pulse k" is the testack level while pulse k is high.
  - Response k is computed on the synced falling edge of pulse k-1 and held until the next synced falling edge.
  - testack never changes while synced testreq is high.
- Break detection:
  - Break = synced testreq low for BREAK_CYCLES consecutive cycles.
  - A break from any state forces IDLE, clears the pulse counter and sets testack=0.
  - If the break occurs in DATA, aborted pulses for one cycle; the popped word is discarded.
- IDLE:
  - Count rising edges.
  - On the falling edge of pulse INPUT_PULSES, go to WAIT, clear the wait counter and clear timeout.
  - The response during the command pulses is 0.
- WAIT, on each falling edge:
  - FIFO non-empty: pop into the shift register, next response = 1 (ACK), go to DATA with bit count 0.
  - FIFO empty: next response = 0 (NACK) and increment the wait counter. If the wait counter reaches MAX_WAIT, set timeout and go to HALT.
- DATA, on each falling edge:
  - Next response = the next bit (MSB or LSB per MSB_FIRST); the shift register shifts.
  - After DATA_W bits have been presented, the next falling edge re-enters WAIT logic in the same cycle, i.e. chaining: an immediate ACK if the FIFO is non-empty, otherwise NACK.
- HALT: testack=0; all pulses are ignored until a break.
- FIFO:
  - Push and pop are legal in the same cycle, including when full; tx_ready is !full and does not consider a same-cycle pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop in an empty cycle is impossible by construction.
- The wait counter saturates and never wraps.
- A reset mid-transfer aborts silently; aborted is not asserted.

Decomposition:
- postbox_pkg:
  - state enum IDLE/WAIT/DATA/HALT
  - INPUT_PULSES default and future command pulse-count constants
  - clog2 helper
- Sub-module postbox_tx_fifo: parametrised sync FIFO with level output.

Test Plan:
- Reset, 4 pulses with no data, then 3 NACK waits; push 0x5A during the 3rd; continue pulsing -> responses 0,0,0,1 then 0,1,0,1,1,0,1,0; shift register = 0x5A; busy returns 0 after break.
- Push 0xA5 and 0x3C before the command; 4 command pulses plus 18 pulses -> ACK,A5 bits,ACK,3C bits contiguous with no NACK between words.
- MSB_FIRST=0, DATA_W=12, push 0x123 -> bits 1,1,0,0,0,1,0,0,1,0,0,0 after ACK.
- MAX_WAIT=5, empty FIFO, 4 command pulses plus 10 pulses -> 5 NACKs then timeout=1 and testack stays 0; after a break plus a new command, timeout clears.
- Break (30us low) after 3 data bits -> aborted pulses once, state IDLE, fifo_level decremented by 1, next command works normally.
- Push 5 words with FIFO_DEPTH=4 -> tx_ready=0 after 4 pushes; a push and a pop in the same cycle while full keeps fifo_level=4.
